// File: rtl/bp_me_io_cmd_arbiter_if.sv
// Requester-side and IO-link-side handshake bundle for the IO command arbiter.
// The arbiter takes the master modport and the environment takes the slave modport.
interface bp_me_io_cmd_arbiter_if #(
    parameter int num_req_p      = 2,
    parameter int io_msg_width_p = 64
);
    logic [num_req_p*io_msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]                req_cmd_v_i;
    logic [num_req_p-1:0]                req_cmd_yumi_o;
    logic [io_msg_width_p-1:0]           req_resp_o;
    logic [num_req_p-1:0]                req_resp_v_o;
    logic [num_req_p-1:0]                req_resp_ready_i;

    logic [io_msg_width_p-1:0]           io_cmd_o;
    logic                                io_cmd_v_o;
    logic                                io_cmd_ready_i;
    logic [io_msg_width_p-1:0]           io_resp_i;
    logic                                io_resp_v_i;
    logic                                io_resp_yumi_o;

    modport master (
        input  req_cmd_i, req_cmd_v_i, req_resp_ready_i,
        input  io_cmd_ready_i, io_resp_i, io_resp_v_i,
        output req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        output io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );

    modport slave (
        output req_cmd_i, req_cmd_v_i, req_resp_ready_i,
        output io_cmd_ready_i, io_resp_i, io_resp_v_i,
        input  req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        input  io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );
endinterface

// File: rtl/bp_me_io_cmd_arbiter.sv
// Round-robin arbiter multiplexing several IO command requesters onto one IO link.
// A tag FIFO remembers issue order so each response returns to its originating requester.
module bp_me_io_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int io_msg_width_p    = 64,
    parameter int max_outstanding_p = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    bp_me_io_cmd_arbiter_if.master                 bus,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   err_o
);
    localparam int tag_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_w = $clog2(max_outstanding_p+1);

    logic [tag_w-1:0] last_r;
    logic [tag_w-1:0] tag_mem [max_outstanding_p];
    logic [ptr_w-1:0] wr_ptr_r, rd_ptr_r;
    logic [cnt_w-1:0] count_r;
    logic             err_r;

    logic             grant_v;
    logic [tag_w-1:0] grant_idx;
    logic [tag_w-1:0] head_tag;
    logic             full, empty, fire, pop, resp_route;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(max_outstanding_p-1)) ? '0 : p + ptr_w'(1);
    endfunction

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        int idx;
        grant_v   = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 1; k <= num_req_p; k++) begin
            idx = (int'(last_r) + k) % num_req_p;
            if (!grant_v && bus.req_cmd_v_i[idx]) begin
                grant_v   = 1'b1;
                grant_idx = tag_w'(idx);
            end
        end
    end

    assign full     = (count_r == cnt_w'(max_outstanding_p));
    assign empty    = (count_r == '0);
    assign head_tag = tag_mem[rd_ptr_r];

    // Reset gating keeps every control output low while reset_i is held.
    assign bus.io_cmd_v_o = grant_v & ~full & ~reset_i;
    assign bus.io_cmd_o   = grant_v ? bus.req_cmd_i[grant_idx*io_msg_width_p +: io_msg_width_p] : '0;
    assign fire           = bus.io_cmd_v_o & bus.io_cmd_ready_i;

    always_comb begin
        bus.req_cmd_yumi_o = '0;
        bus.req_resp_v_o   = '0;
        for (int i = 0; i < num_req_p; i++) begin
            bus.req_cmd_yumi_o[i] = fire && (grant_idx == tag_w'(i));
            bus.req_resp_v_o[i]   = resp_route && (head_tag == tag_w'(i));
        end
    end

    assign resp_route         = bus.io_resp_v_i & ~empty & ~reset_i;
    assign bus.io_resp_yumi_o = resp_route & bus.req_resp_ready_i[head_tag];
    assign bus.req_resp_o     = bus.io_resp_i;
    assign pop                = bus.io_resp_yumi_o;

    assign outstanding_o = reset_i ? '0 : count_r;
    assign err_o         = err_r & ~reset_i;

    // NOTE: the tag storage is not reset; occupancy is tracked by count_r, so stale entries are never read.
    always_ff @(posedge clk_i) begin
        if (fire) tag_mem[wr_ptr_r] <= grant_idx;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r   <= tag_w'(num_req_p-1);
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            if (fire) begin
                last_r   <= grant_idx;
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({fire, pop})
                2'b10:   count_r <= count_r + cnt_w'(1);
                2'b01:   count_r <= count_r - cnt_w'(1);
                default: count_r <= count_r;
            endcase
            if (bus.io_resp_v_i && empty) err_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Scenario bench for the IO command arbiter: issue order is queued at command fire
// and popped when the matching response is routed back.
module tb_bp_me_io_cmd_arbiter;
    localparam int nr = 2;
    localparam int w  = 16;
    localparam int mo = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] outstanding;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int model_last  = 1;

    bp_me_io_cmd_arbiter_if #(.num_req_p(nr), .io_msg_width_p(w)) bus ();

    bp_me_io_cmd_arbiter #(.num_req_p(nr), .io_msg_width_p(w), .max_outstanding_p(mo)) dut (
        .clk_i(clk), .reset_i(reset), .bus(bus.master),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [w-1:0] payload(input int r);
        return (r == 0) ? 16'hA0A0 : 16'hB1B1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_cmd_v_i = 2'b11; bus.io_cmd_ready_i = 1'b1;
        bus.io_resp_v_i = 1'b1;  bus.req_resp_ready_i = 2'b11;
        cyc(); cyc();
        vectors++; if (bus.io_cmd_v_o !== 1'b0) begin miscompares++; $display("FAIL rst_io_cmd_v got %b want 0", bus.io_cmd_v_o); end
        vectors++; if (bus.req_cmd_yumi_o !== 2'b00) begin miscompares++; $display("FAIL rst_yumi got %b want 00", bus.req_cmd_yumi_o); end
        vectors++; if (bus.req_resp_v_o !== 2'b00) begin miscompares++; $display("FAIL rst_resp_v got %b want 00", bus.req_resp_v_o); end
        vectors++; if (bus.io_resp_yumi_o !== 1'b0) begin miscompares++; $display("FAIL rst_resp_yumi got %b want 0", bus.io_resp_yumi_o); end
        vectors++; if (outstanding !== 2'd0) begin miscompares++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", err); end
        reset = 1'b0;
        bus.req_cmd_v_i = 2'b00; bus.io_resp_v_i = 1'b0;
        exp_q.delete(); model_last = 1;
        cyc();
    endtask

    task automatic test_round_robin();
        bus.req_cmd_v_i = 2'b11; bus.io_cmd_ready_i = 1'b1; bus.req_resp_ready_i = 2'b11;
        for (int i = 0; i < 6; i++) begin
            automatic int win;
            automatic int head;
            bus.io_resp_v_i = (exp_q.size() != 0);
            bus.io_resp_i   = 16'hC000 + 16'(i);
            #1;
            win = (model_last + 1) % nr;
            vectors++; if (outstanding !== 2'(exp_q.size())) begin miscompares++; $display("FAIL rr_outstanding[%0d] got %0d want %0d", i, outstanding, exp_q.size()); end
            vectors++; if (bus.io_cmd_v_o !== 1'b1) begin miscompares++; $display("FAIL rr_cmd_v[%0d] got %b want 1", i, bus.io_cmd_v_o); end
            vectors++; if (bus.req_cmd_yumi_o !== 2'(1 << win)) begin miscompares++; $display("FAIL rr_yumi[%0d] got %b want %b", i, bus.req_cmd_yumi_o, 2'(1 << win)); end
            vectors++; if (bus.io_cmd_o !== payload(win)) begin miscompares++; $display("FAIL rr_cmd[%0d] got %h want %h", i, bus.io_cmd_o, payload(win)); end
            if (bus.io_resp_v_i) begin
                head = exp_q.pop_front();
                vectors++; if (bus.req_resp_v_o !== 2'(1 << head)) begin miscompares++; $display("FAIL rr_resp_v[%0d] got %b want %b", i, bus.req_resp_v_o, 2'(1 << head)); end
                vectors++; if (bus.io_resp_yumi_o !== 1'b1) begin miscompares++; $display("FAIL rr_resp_yumi[%0d] got %b want 1", i, bus.io_resp_yumi_o); end
                vectors++; if (bus.req_resp_o !== 16'hC000 + 16'(i)) begin miscompares++; $display("FAIL rr_resp_data[%0d] got %h want %h", i, bus.req_resp_o, 16'hC000 + 16'(i)); end
            end
            exp_q.push_back(win);
            model_last = win;
            cyc();
        end
        bus.req_cmd_v_i = 2'b00; bus.io_resp_v_i = 1'b1;
        #1;
        begin
            automatic int head = exp_q.pop_front();
            vectors++; if (bus.req_resp_v_o !== 2'(1 << head)) begin miscompares++; $display("FAIL rr_drain_v got %b want %b", bus.req_resp_v_o, 2'(1 << head)); end
        end
        cyc();
        bus.io_resp_v_i = 1'b0;
        #1;
        vectors++; if (outstanding !== 2'd0) begin miscompares++; $display("FAIL rr_drained got %0d want 0", outstanding); end
    endtask

    task automatic test_stall();
        bus.req_cmd_v_i = 2'b11; bus.io_cmd_ready_i = 1'b0; bus.io_resp_v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (bus.io_cmd_v_o !== 1'b1) begin miscompares++; $display("FAIL stall_cmd_v[%0d] got %b want 1", i, bus.io_cmd_v_o); end
            vectors++; if (bus.req_cmd_yumi_o !== 2'b00) begin miscompares++; $display("FAIL stall_yumi[%0d] got %b want 00", i, bus.req_cmd_yumi_o); end
            vectors++; if (bus.io_cmd_o !== payload(0)) begin miscompares++; $display("FAIL stall_grant[%0d] got %h want %h", i, bus.io_cmd_o, payload(0)); end
            cyc();
        end
        bus.io_cmd_ready_i = 1'b1;
        #1;
        vectors++; if (bus.req_cmd_yumi_o !== 2'b01) begin miscompares++; $display("FAIL stall_release got %b want 01", bus.req_cmd_yumi_o); end
        exp_q.push_back(0); model_last = 0;
        cyc();
        bus.req_cmd_v_i = 2'b00; bus.io_resp_v_i = 1'b1; bus.io_resp_i = 16'h5A5A;
        #1;
        begin
            automatic int head = exp_q.pop_front();
            vectors++; if (bus.req_resp_v_o !== 2'(1 << head)) begin miscompares++; $display("FAIL stall_resp_v got %b want %b", bus.req_resp_v_o, 2'(1 << head)); end
        end
        vectors++; if (bus.io_resp_yumi_o !== 1'b1) begin miscompares++; $display("FAIL stall_resp_yumi got %b want 1", bus.io_resp_yumi_o); end
        cyc();
        bus.io_resp_v_i = 1'b0;
    endtask

    task automatic test_full();
        bus.req_cmd_v_i = 2'b11; bus.io_cmd_ready_i = 1'b1; bus.io_resp_v_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            automatic int win;
            #1;
            win = (model_last + 1) % nr;
            vectors++; if (bus.req_cmd_yumi_o !== 2'(1 << win)) begin miscompares++; $display("FAIL full_fill_yumi[%0d] got %b want %b", i, bus.req_cmd_yumi_o, 2'(1 << win)); end
            exp_q.push_back(win); model_last = win;
            cyc();
        end
        #1;
        vectors++; if (outstanding !== 2'd2) begin miscompares++; $display("FAIL full_outstanding got %0d want 2", outstanding); end
        vectors++; if (bus.io_cmd_v_o !== 1'b0) begin miscompares++; $display("FAIL full_cmd_v got %b want 0", bus.io_cmd_v_o); end
        vectors++; if (bus.req_cmd_yumi_o !== 2'b00) begin miscompares++; $display("FAIL full_yumi got %b want 00", bus.req_cmd_yumi_o); end
        cyc();
        bus.io_resp_v_i = 1'b1; bus.io_resp_i = 16'h1111;
        #1;
        vectors++; if (bus.io_cmd_v_o !== 1'b0) begin miscompares++; $display("FAIL full_pop_cmd_v got %b want 0", bus.io_cmd_v_o); end
        begin
            automatic int head = exp_q.pop_front();
            vectors++; if (bus.req_resp_v_o !== 2'(1 << head)) begin miscompares++; $display("FAIL full_resp_v got %b want %b", bus.req_resp_v_o, 2'(1 << head)); end
        end
        vectors++; if (bus.io_resp_yumi_o !== 1'b1) begin miscompares++; $display("FAIL full_resp_yumi got %b want 1", bus.io_resp_yumi_o); end
        cyc();
        bus.io_resp_v_i = 1'b0;
        #1;
        vectors++; if (outstanding !== 2'd1) begin miscompares++; $display("FAIL full_after_pop got %0d want 1", outstanding); end
        begin
            automatic int win = (model_last + 1) % nr;
            vectors++; if (bus.req_cmd_yumi_o !== 2'(1 << win)) begin miscompares++; $display("FAIL full_reissue got %b want %b", bus.req_cmd_yumi_o, 2'(1 << win)); end
            exp_q.push_back(win); model_last = win;
        end
        cyc();
        bus.req_cmd_v_i = 2'b00;
    endtask

    task automatic test_backpressure();
        bus.io_resp_v_i = 1'b1; bus.req_resp_ready_i = 2'b00; bus.io_resp_i = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (bus.req_resp_v_o !== 2'(1 << exp_q[0])) begin miscompares++; $display("FAIL bp_resp_v[%0d] got %b want %b", i, bus.req_resp_v_o, 2'(1 << exp_q[0])); end
            vectors++; if (bus.io_resp_yumi_o !== 1'b0) begin miscompares++; $display("FAIL bp_yumi[%0d] got %b want 0", i, bus.io_resp_yumi_o); end
            vectors++; if (outstanding !== 2'd2) begin miscompares++; $display("FAIL bp_hold[%0d] got %0d want 2", i, outstanding); end
            cyc();
        end
        bus.req_resp_ready_i = 2'(1 << exp_q[0]);
        #1;
        vectors++; if (bus.io_resp_yumi_o !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b want 1", bus.io_resp_yumi_o); end
        void'(exp_q.pop_front());
        cyc();
        bus.req_resp_ready_i = 2'b11;
        #1;
        vectors++; if (outstanding !== 2'd1) begin miscompares++; $display("FAIL bp_after_pop got %0d want 1", outstanding); end
        begin
            automatic int head = exp_q.pop_front();
            vectors++; if (bus.req_resp_v_o !== 2'(1 << head)) begin miscompares++; $display("FAIL bp_second_v got %b want %b", bus.req_resp_v_o, 2'(1 << head)); end
        end
        cyc();
        bus.io_resp_v_i = 1'b0;
        #1;
        vectors++; if (outstanding !== 2'd0) begin miscompares++; $display("FAIL bp_drained got %0d want 0", outstanding); end
    endtask

    task automatic test_err();
        reset = 1'b1; cyc(); reset = 1'b0;
        exp_q.delete(); model_last = 1;
        bus.io_resp_v_i = 1'b1; bus.req_resp_ready_i = 2'b11;
        #1;
        vectors++; if (bus.io_resp_yumi_o !== 1'b0) begin miscompares++; $display("FAIL err_yumi got %b want 0", bus.io_resp_yumi_o); end
        vectors++; if (bus.req_resp_v_o !== 2'b00) begin miscompares++; $display("FAIL err_resp_v got %b want 00", bus.req_resp_v_o); end
        cyc();
        bus.io_resp_v_i = 1'b0;
        #1;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_set got %b want 1", err); end
        repeat (3) cyc();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", err); end
    endtask

    task automatic test_reset_midflight();
        bus.req_cmd_v_i = 2'b10; bus.io_cmd_ready_i = 1'b1;
        #1;
        vectors++; if (bus.req_cmd_yumi_o !== 2'b10) begin miscompares++; $display("FAIL mid_issue got %b want 10", bus.req_cmd_yumi_o); end
        exp_q.push_back(1); model_last = 1;
        cyc();
        bus.req_cmd_v_i = 2'b00;
        #1;
        vectors++; if (outstanding !== 2'd1) begin miscompares++; $display("FAIL mid_outstanding got %0d want 1", outstanding); end
        reset = 1'b1; bus.req_cmd_v_i = 2'b11;
        #1;
        vectors++; if (bus.io_cmd_v_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_cmd_v got %b want 0", bus.io_cmd_v_o); end
        cyc();
        reset = 1'b0; exp_q.delete(); model_last = 1;
        #1;
        vectors++; if (outstanding !== 2'd0) begin miscompares++; $display("FAIL mid_cleared got %0d want 0", outstanding); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL mid_err_cleared got %b want 0", err); end
        vectors++; if (bus.req_cmd_yumi_o !== 2'b01) begin miscompares++; $display("FAIL mid_first_grant got %b want 01", bus.req_cmd_yumi_o); end
        exp_q.push_back(0); model_last = 0;
        cyc();
        bus.req_cmd_v_i = 2'b00; bus.io_resp_v_i = 1'b1;
        #1;
        begin
            automatic int head = exp_q.pop_front();
            vectors++; if (bus.req_resp_v_o !== 2'(1 << head)) begin miscompares++; $display("FAIL mid_resp_v got %b want %b", bus.req_resp_v_o, 2'(1 << head)); end
        end
        cyc();
        #1;
        vectors++; if (bus.io_resp_yumi_o !== 1'b0) begin miscompares++; $display("FAIL mid_late_yumi got %b want 0", bus.io_resp_yumi_o); end
        cyc();
        bus.io_resp_v_i = 1'b0;
        #1;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL mid_late_err got %b want 1", err); end
    endtask

    initial begin
        reset = 1'b1;
        bus.req_cmd_i        = {16'hB1B1, 16'hA0A0};
        bus.req_cmd_v_i      = '0;
        bus.req_resp_ready_i = '0;
        bus.io_cmd_ready_i   = 1'b0;
        bus.io_resp_i        = '0;
        bus.io_resp_v_i      = 1'b0;
        test_reset();
        test_round_robin();
        test_stall();
        test_full();
        test_backpressure();
        test_err();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bp_me_io_cmd_arbiter.md
BP_ME_IO_CMD_ARBITER -- requirements
Module: bp_me_io_cmd_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of IO command requesters (nbf loader, cfg loader, ...), range 2..8.
REQ-002 SHALL have parameter io_msg_width_p, default the width of bp_cce_io_msg_s for bp_params_p: width of one IO command or response message.
REQ-003 SHALL have parameter max_outstanding_p, default 4: number of IO commands that may await a response, range 1..16.
REQ-004 clk_i  in  1  single clock.
REQ-005 reset_i  in  1  reset, synchronous to clk_i, active-high.
REQ-006 req_cmd_i  in  num_req_p*io_msg_width_p  requester commands; slice i belongs to requester i.
REQ-007 req_cmd_v_i  in  num_req_p  per-requester command valid.
REQ-008 req_cmd_yumi_o  out  num_req_p  per-requester command consumed; at most one bit set.
REQ-009 req_resp_o  out  io_msg_width_p  response payload, broadcast to all requesters.
REQ-010 req_resp_v_o  out  num_req_p  per-requester response valid; at most one bit set.
REQ-011 req_resp_ready_i  in  num_req_p  per-requester response ready.
REQ-012 io_cmd_o  out  io_msg_width_p  command to the shared IO link.
REQ-013 io_cmd_v_o  out  1  command valid to the IO link.
REQ-014 io_cmd_ready_i  in  1  IO link ready.
REQ-015 io_resp_i  in  io_msg_width_p  response from the IO link.
REQ-016 io_resp_v_i  in  1  response valid.
REQ-017 io_resp_yumi_o  out  1  response consumed.
REQ-018 outstanding_o  out  clog2(max_outstanding_p+1)  current in-flight count.
REQ-019 err_o  out  1  sticky error flag.

Function
REQ-020 Grant SHALL be round-robin and combinational (zero-cycle latency): the winner is the first valid requester, searching upward with wrap-around, starting at last_r+1 mod num_req_p.
REQ-021 io_cmd_v_o SHALL be (|req_cmd_v_i) & ~full. io_cmd_o SHALL be the granted slice, or 0 when nothing is valid.
REQ-022 The command fires when io_cmd_v_o & io_cmd_ready_i. On fire, req_cmd_yumi_o SHALL be set for the winner only, and the winner index SHALL be pushed into the tag FIFO.
REQ-023 last_r SHALL update to the winner only on fire. A stalled grant SHALL NOT rotate priority.
REQ-024 The tag FIFO SHALL be depth max_outstanding_p, in order, with full = (count == max_outstanding_p) and empty = (count == 0).
REQ-025 When full, no command SHALL be issued, even if a response dequeues in the same cycle.
REQ-026 Responses SHALL be routed to the requester at the FIFO head.
- req_resp_v_o[head] = io_resp_v_i & ~empty.
- io_resp_yumi_o = io_resp_v_i & ~empty & req_resp_ready_i[head]; on this event the FIFO pops.
- req_resp_o = io_resp_i, passthrough.
REQ-027 Simultaneous push and pop SHALL leave the count unchanged. Both pointers SHALL wrap modulo max_outstanding_p.
REQ-028 io_resp_v_i while empty SHALL NOT be consumed, and SHALL set err_o.
REQ-029 A requester dropping valid without a yumi SHALL be tolerated, and arbitration SHALL re-evaluate in the next cycle.
REQ-030 outstanding_o SHALL equal the FIFO count and SHALL update on the cycle after a push or pop.

Reset
REQ-031 While reset_i is high, all outputs SHALL be 0 except req_resp_o and io_cmd_o, which are don't-care.
REQ-032 On reset, last_r SHALL be num_req_p-1, so requester 0 has first priority; count, pointers and err_o SHALL be 0.
REQ-033 Reset mid-operation SHALL discard in-flight tags. Responses arriving afterwards SHALL follow REQ-028.

Verification
REQ-034 Bench SHALL cover these scenarios (num_req_p=2, max_outstanding_p=2 unless stated):
- Both requesters valid every cycle, io_cmd_ready_i=1, responses returned promptly -> yumi alternates 0,1,0,1; each response is delivered to the requester in issue order.
- io_cmd_ready_i held 0 for 3 cycles with both requesters valid -> grant stays on requester 0, no yumi, last_r unchanged; fires on requester 0 when ready rises.
- Two commands issued with no responses -> outstanding_o=2, io_cmd_v_o=0 despite valid; the first response pops the FIFO, and the next cycle permits an issue.
- Response with req_resp_ready_i[head]=0 for 2 cycles -> io_resp_yumi_o=0 and the FIFO holds; consumed in the cycle ready rises.
- io_resp_v_i=1 after reset with nothing issued -> io_resp_yumi_o=0, err_o=1 and remains 1 until reset.
- Reset asserted with 1 outstanding -> outstanding_o=0; requester 0 is granted first after reset.
